tastable_clk_supervisor: RTL

Sits directly downstream of the 21 MHz→168 MHz iCE40 PLL wrapper. It runs on the PLL global output and consumes the PLL LOCK signal. It holds the core logic in reset until lock has been stable for a programmable time, and drops reset again if lock is lost. It also generates a divided clock-enable tick for the console-timing logic and counts lock-loss events for debug readback.

---
 rtl/tastable_clk_supervisor.sv | 83 ++++++++
 1 files changed

// File: rtl/tastable_clk_supervisor.sv
// tastable_clk_supervisor: holds core reset until PLL lock has been stable,
// generates the RUN-only clock-enable tick and counts lock-loss events.
module tastable_clk_supervisor #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CE_DIV             = 168,
    parameter int CNT_W              = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOCK,
    input  logic             CLR_CNT,
    output logic             SYS_RESETN,
    output logic             CE_TICK,
    output logic [CNT_W-1:0] LOCK_LOST_CNT,
    output logic [1:0]       STATE
);
    localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CE_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        SETTLE    = 2'b01,
        RUN       = 2'b10,
        LOST      = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             lock_meta_q, lock_s_q;
    logic [SW-1:0]    settle_q, settle_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_resetn_q;
    logic             lost_evt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= WAIT_LOCK;
            settle_q     <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            sys_resetn_q <= 1'b0;
        end else begin
            lock_meta_q  <= LOCK;
            lock_s_q     <= lock_meta_q;
            state_q      <= state_d;
            settle_q     <= settle_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            sys_resetn_q <= (state_d == RUN);
        end
    end

    // Any drop of lock_s during SETTLE restarts the full stability wait.
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            WAIT_LOCK: if (lock_s_q) state_d = SETTLE;
            SETTLE: begin
                if (!lock_s_q)                  state_d = WAIT_LOCK;
                else if (settle_q == SETTLE_LAST) state_d = RUN;
                else                            settle_d = settle_q + 1'b1;
            end
            RUN:     if (!lock_s_q) state_d = LOST;
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign lost_evt = (state_q == RUN) && !lock_s_q;
    assign div_d    = (state_q == RUN && state_d == RUN && div_q != DIV_LAST) ? div_q + 1'b1 : '0;
    // A clear coinciding with a loss still records that loss.
    assign cnt_d    = CLR_CNT ? CNT_W'(lost_evt)
                    : (lost_evt && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    assign SYS_RESETN    = sys_resetn_q;
    assign CE_TICK       = (state_q == RUN) && (div_q == DIV_LAST);
    assign LOCK_LOST_CNT = cnt_q;
    assign STATE         = state_q;
endmodule
